// File: rtl/uart_msg_link.sv
// rtl/uart_msg_link.sv - framed word link over a byte-stream UART core with checksum and commit/rollback RX buffer
module uart_msg_link #(
    parameter int         WORD_W      = 16,
    parameter int         TX_DEPTH    = 16,
    parameter int         RX_DEPTH    = 256,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 3472
) (
    input  logic                      CLK,
    input  logic                      RST,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    input  logic [WORD_W-1:0]         DATA,
    input  logic                      ENA,
    input  logic [7:0]                MSG_LEN_IN,
    output logic                      BUSY,
    input  logic                      RD_REQ,
    output logic [WORD_W-1:0]         FIFO_Q,
    output logic [$clog2(RX_DEPTH):0] RX_COUNT,
    output logic [7:0]                MSG_LEN,
    output logic                      GOT_FULL_MESSAGE,
    output logic                      CRC_ERR,
    output logic                      TIMEOUT_ERR,
    output logic                      OVF_ERR
);
    localparam int WB  = WORD_W / 8;
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int BW  = (WB > 1) ? $clog2(WB) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {T_IDLE, T_SYNC, T_LEN, T_DATA, T_CHK} tx_state_t;
    typedef enum logic [1:0] {R_SYNC, R_LEN, R_DATA, R_CHK} rx_state_t;

    tx_state_t            r_tx_state, w_tx_state_nxt;
    logic [WORD_W-1:0]    r_tx_mem [TX_DEPTH];
    logic [TAW:0]         r_tx_wp, r_tx_rp, w_tx_cnt, w_tx_cnt_nxt;
    logic [7:0]           r_n, r_acc, r_sent, r_tx_chk, w_acc_nxt, w_n_nxt;
    logic [BW-1:0]        r_tx_bidx;
    logic                 r_busy, w_tx_empty, w_tx_full, w_push, w_pop, w_tx_hs, w_tx_done;
    logic [WB-1:0][7:0]   w_tx_bytes;

    assign w_tx_cnt     = r_tx_wp - r_tx_rp;
    assign w_tx_empty   = (w_tx_cnt == '0);
    assign w_tx_full    = (w_tx_cnt == (TAW+1)'(TX_DEPTH));
    assign w_push       = ENA && !r_busy && !w_tx_full &&
                          ((r_acc == 8'd0) ? (MSG_LEN_IN != 8'd0) : (r_acc < r_n));
    assign w_tx_hs      = tx_valid && tx_ready;
    assign w_tx_bytes   = r_tx_mem[r_tx_rp[TAW-1:0]];
    assign w_n_nxt      = (w_push && r_acc == 8'd0) ? MSG_LEN_IN : r_n;
    assign w_acc_nxt    = w_tx_done ? 8'd0 : (w_push ? r_acc + 8'd1 : r_acc);
    assign w_tx_cnt_nxt = w_tx_cnt + (TAW+1)'(w_push) - (TAW+1)'(w_pop);
    assign BUSY         = r_busy;

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        tx_valid       = 1'b0;
        tx_data        = 8'h00;
        w_pop          = 1'b0;
        w_tx_done      = 1'b0;
        case (r_tx_state)
            T_IDLE: if (r_acc != 8'd0 && !w_tx_empty) w_tx_state_nxt = T_SYNC;
            T_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) w_tx_state_nxt = T_LEN;
            end
            T_LEN: begin
                tx_valid = 1'b1;
                tx_data  = r_n;
                if (tx_ready) w_tx_state_nxt = T_DATA;
            end
            T_DATA: begin
                // An underrun mid-message just stalls the byte stream until the next word arrives.
                tx_valid = !w_tx_empty;
                tx_data  = w_tx_empty ? 8'h00 : w_tx_bytes[BW'(WB - 1) - r_tx_bidx];
                if (!w_tx_empty && tx_ready && r_tx_bidx == BW'(WB - 1)) begin
                    w_pop = 1'b1;
                    if (r_sent == r_n - 8'd1) w_tx_state_nxt = T_CHK;
                end
            end
            T_CHK: begin
                tx_valid = 1'b1;
                tx_data  = r_tx_chk;
                if (tx_ready) begin
                    w_tx_done      = 1'b1;
                    w_tx_state_nxt = T_IDLE;
                end
            end
            default: w_tx_state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_tx_mem[r_tx_wp[TAW-1:0]] <= DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx_state <= T_IDLE;
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_n        <= 8'd0;
            r_acc      <= 8'd0;
            r_sent     <= 8'd0;
            r_tx_chk   <= 8'd0;
            r_tx_bidx  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_n        <= w_n_nxt;
            r_acc      <= w_acc_nxt;
            r_busy     <= (w_tx_cnt_nxt == (TAW+1)'(TX_DEPTH)) || (w_acc_nxt != 8'd0 && w_acc_nxt == w_n_nxt);
            if (w_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_tx_hs) begin
                case (r_tx_state)
                    T_LEN:  r_tx_chk <= r_n;
                    T_DATA: begin
                        r_tx_chk  <= r_tx_chk ^ tx_data;
                        r_tx_bidx <= w_pop ? '0 : r_tx_bidx + 1'b1;
                        if (w_pop) r_sent <= r_sent + 8'd1;
                    end
                    T_CHK:  r_sent <= 8'd0;
                    default: ;
                endcase
            end
        end
    end

    rx_state_t            r_rx_state, w_rx_state_nxt;
    logic [WORD_W-1:0]    r_rx_mem [RX_DEPTH];
    logic [RAW:0]         r_rd_ptr, r_wr_ptr, r_sp_ptr, w_used;
    logic [RAW+1:0]       w_free;
    logic [7:0]           r_len, r_wcnt, r_rx_chk, r_msg_len;
    logic [BW-1:0]        r_rx_bidx;
    logic [WORD_W-1:0]    r_rword, w_rword_nxt;
    logic [TW-1:0]        r_tmo;
    logic                 r_drop, r_rx_ready, r_got, r_crc, r_tmo_err, r_ovf;
    logic                 w_rx_hs, w_timeout, w_word_done, w_rd;

    assign w_rx_hs     = rx_valid && r_rx_ready;
    assign w_rword_nxt = WORD_W'({r_rword, rx_data});
    assign w_word_done = w_rx_hs && r_rx_state == R_DATA && r_rx_bidx == BW'(WB - 1);
    assign w_used      = r_sp_ptr - r_rd_ptr;
    assign w_free      = (RAW+2)'(RX_DEPTH) - (RAW+2)'(w_used);
    assign w_timeout   = (r_rx_state != R_SYNC) && !rx_valid && (r_tmo == TW'(TIMEOUT_CYC - 1));
    assign RX_COUNT    = r_wr_ptr - r_rd_ptr;
    assign w_rd        = RD_REQ && (RX_COUNT != '0);
    assign FIFO_Q      = (RX_COUNT != '0) ? r_rx_mem[r_rd_ptr[RAW-1:0]] : '0;
    assign rx_ready    = r_rx_ready;
    assign MSG_LEN     = r_msg_len;
    assign GOT_FULL_MESSAGE = r_got;
    assign CRC_ERR     = r_crc;
    assign TIMEOUT_ERR = r_tmo_err;
    assign OVF_ERR     = r_ovf;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        if (w_timeout) begin
            w_rx_state_nxt = R_SYNC;
        end else if (w_rx_hs) begin
            case (r_rx_state)
                R_SYNC: if (rx_data == SYNC_BYTE) w_rx_state_nxt = R_LEN;
                R_LEN:  w_rx_state_nxt = (rx_data == 8'd0) ? R_SYNC : R_DATA;
                R_DATA: if (r_rx_bidx == BW'(WB - 1) && r_wcnt == r_len - 8'd1) w_rx_state_nxt = R_CHK;
                R_CHK:  w_rx_state_nxt = R_SYNC;
                default: w_rx_state_nxt = R_SYNC;
            endcase
        end
    end

    // Words land beyond the committed pointer and stay invisible until the checksum commits them.
    always_ff @(posedge CLK) begin
        if (w_word_done && !r_drop) r_rx_mem[r_sp_ptr[RAW-1:0]] <= w_rword_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_state <= R_SYNC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_sp_ptr   <= '0;
            r_len      <= 8'd0;
            r_wcnt     <= 8'd0;
            r_rx_chk   <= 8'd0;
            r_msg_len  <= 8'd0;
            r_rx_bidx  <= '0;
            r_rword    <= '0;
            r_tmo      <= '0;
            r_drop     <= 1'b0;
            r_rx_ready <= 1'b0;
            r_got      <= 1'b0;
            r_crc      <= 1'b0;
            r_tmo_err  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_ready <= 1'b1;
            r_got      <= 1'b0;
            r_crc      <= 1'b0;
            r_tmo_err  <= 1'b0;
            r_ovf      <= 1'b0;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_tmo <= (r_rx_state == R_SYNC || rx_valid) ? '0 : r_tmo + TW'(1);
            if (w_timeout) begin
                r_sp_ptr  <= r_wr_ptr;
                r_tmo_err <= 1'b1;
            end else if (w_rx_hs) begin
                case (r_rx_state)
                    R_LEN: begin
                        r_len     <= rx_data;
                        r_rx_chk  <= rx_data;
                        r_drop    <= (32'(rx_data) > 32'(w_free));
                        r_wcnt    <= 8'd0;
                        r_rx_bidx <= '0;
                    end
                    R_DATA: begin
                        r_rx_chk <= r_rx_chk ^ rx_data;
                        r_rword  <= w_rword_nxt;
                        if (r_rx_bidx == BW'(WB - 1)) begin
                            r_rx_bidx <= '0;
                            r_wcnt    <= r_wcnt + 8'd1;
                            if (!r_drop) r_sp_ptr <= r_sp_ptr + 1'b1;
                        end else begin
                            r_rx_bidx <= r_rx_bidx + 1'b1;
                        end
                    end
                    R_CHK: begin
                        if (r_drop) begin
                            r_ovf    <= 1'b1;
                            r_sp_ptr <= r_wr_ptr;
                        end else if (rx_data == r_rx_chk) begin
                            r_wr_ptr  <= r_sp_ptr;
                            r_got     <= 1'b1;
                            r_msg_len <= r_len;
                        end else begin
                            r_crc    <= 1'b1;
                            r_sp_ptr <= r_wr_ptr;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_msg_link.sv
// tb/tb_uart_msg_link.sv - self-checking bench for uart_msg_link with a queue-based frame model
module tb_uart_msg_link;
    typedef logic [7:0] bq_t[$];
    typedef logic [15:0] wq_t[$];
    localparam int T0 = 3472;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [7:0]  tx_data0, rx_data0 = 8'h00, MSG_LEN_IN0 = 8'h00, MSG_LEN0;
    logic        tx_valid0, tx_ready0 = 1'b0, rx_valid0 = 1'b0, rx_ready0, ENA0 = 1'b0, BUSY0, RD_REQ0 = 1'b0;
    logic [15:0] DATA0 = 16'h0, FIFO_Q0;
    logic [8:0]  RX_COUNT0;
    logic        got0, crc0, tmo0, ovf0;

    logic [7:0]  tx_data1, rx_data1 = 8'h00, MSG_LEN1;
    logic        tx_valid1, rx_valid1 = 1'b0, rx_ready1, BUSY1, RD_REQ1 = 1'b0;
    logic [15:0] FIFO_Q1;
    logic [2:0]  RX_COUNT1;
    logic        got1, crc1, tmo1, ovf1;

    uart_msg_link u0 (
        .CLK(CLK), .RST(RST), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0), .DATA(DATA0), .ENA(ENA0),
        .MSG_LEN_IN(MSG_LEN_IN0), .BUSY(BUSY0), .RD_REQ(RD_REQ0), .FIFO_Q(FIFO_Q0), .RX_COUNT(RX_COUNT0),
        .MSG_LEN(MSG_LEN0), .GOT_FULL_MESSAGE(got0), .CRC_ERR(crc0), .TIMEOUT_ERR(tmo0), .OVF_ERR(ovf0));

    uart_msg_link #(.RX_DEPTH(4), .TIMEOUT_CYC(40)) u1 (
        .CLK(CLK), .RST(RST), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(1'b0),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1), .DATA(16'h0), .ENA(1'b0),
        .MSG_LEN_IN(8'h00), .BUSY(BUSY1), .RD_REQ(RD_REQ1), .FIFO_Q(FIFO_Q1), .RX_COUNT(RX_COUNT1),
        .MSG_LEN(MSG_LEN1), .GOT_FULL_MESSAGE(got1), .CRC_ERR(crc1), .TIMEOUT_ERR(tmo1), .OVF_ERR(ovf1));

    int n_checks = 0, n_fail = 0;
    int c_got0 = 0, c_crc0 = 0, c_tmo0 = 0, c_ovf0 = 0, c_got1 = 0, c_crc1 = 0, c_ovf1 = 0;
    logic [7:0]  cap[$];
    logic [15:0] rx_model[$];

    always @(negedge CLK) begin
        if (tx_valid0 && tx_ready0) cap.push_back(tx_data0);
        if (got0) c_got0++;
        if (crc0) c_crc0++;
        if (tmo0) c_tmo0++;
        if (ovf0) c_ovf0++;
        if (got1) c_got1++;
        if (crc1) c_crc1++;
        if (ovf1) c_ovf1++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bq_t frame_of(input logic [7:0] len, input wq_t w, input logic [7:0] chk_flip);
        bq_t f;
        logic [7:0] x;
        f.push_back(8'hA5);
        f.push_back(len);
        x = len;
        foreach (w[i]) begin
            f.push_back(w[i][15:8]);
            f.push_back(w[i][7:0]);
            x = x ^ w[i][15:8] ^ w[i][7:0];
        end
        f.push_back(x ^ chk_flip);
        return f;
    endfunction

    task automatic send_byte(input int inst, input logic [7:0] b);
        if (inst == 0) begin rx_data0 = b; rx_valid0 = 1'b1; end
        else begin rx_data1 = b; rx_valid1 = 1'b1; end
        tick();
        rx_valid0 = 1'b0;
        rx_valid1 = 1'b0;
    endtask

    task automatic send_frame(input int inst, input bq_t f, input int maxgap);
        foreach (f[i]) begin
            send_byte(inst, f[i]);
            repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    task automatic wait_cap(input int n, input string name);
        int k = 0;
        while (cap.size() < n && k < 300) begin tick(); k++; end
        n_checks++;
        if (cap.size() < n) begin n_fail++; $display("FAIL %s timeout: bytes got %0d need %0d", name, cap.size(), n); end
    endtask

    task automatic cmp_cap(input bq_t exp, input string name);
        bit ok = (cap.size() == exp.size());
        foreach (exp[i]) if (i < cap.size() && cap[i] !== exp[i]) ok = 0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s: got %p expected %p", name, cap, exp); end
    endtask

    task automatic drain_check(input string name);
        while (rx_model.size() > 0) begin
            n_checks++;
            if (RX_COUNT0 !== 9'(rx_model.size()) || FIFO_Q0 !== rx_model[0]) begin
                n_fail++;
                $display("FAIL %s: count %0d q %h expected count %0d q %h", name, RX_COUNT0, FIFO_Q0, rx_model.size(), rx_model[0]);
            end
            RD_REQ0 = 1'b1; tick(); RD_REQ0 = 1'b0;
            void'(rx_model.pop_front());
        end
        n_checks++;
        if (RX_COUNT0 !== 9'd0) begin n_fail++; $display("FAIL %s empty: count %0d expected 0", name, RX_COUNT0); end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({tx_valid0, tx_data0, rx_ready0, BUSY0} !== 11'h0) begin n_fail++; $display("FAIL reset_tx: got %b/%h/%b/%b expected 0", tx_valid0, tx_data0, rx_ready0, BUSY0); end
        n_checks++;
        if ({FIFO_Q0, RX_COUNT0, MSG_LEN0} !== 33'h0) begin n_fail++; $display("FAIL reset_rx: q %h cnt %0d len %0d expected 0", FIFO_Q0, RX_COUNT0, MSG_LEN0); end
        n_checks++;
        if ({got0, crc0, tmo0, ovf0, RX_COUNT1} !== 7'h0) begin n_fail++; $display("FAIL reset_pulses: got %b%b%b%b cnt1 %0d expected 0", got0, crc0, tmo0, ovf0, RX_COUNT1); end
        RST = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (rx_ready0 !== 1'b1) begin n_fail++; $display("FAIL rx_ready: got %b expected 1", rx_ready0); end
    endtask

    task automatic start_two_words();
        MSG_LEN_IN0 = 8'd2; DATA0 = 16'h1234; ENA0 = 1'b1;
        tick();
        DATA0 = 16'hABCD; MSG_LEN_IN0 = 8'd7;
        tick();
        ENA0 = 1'b0;
    endtask

    task automatic test_tx_basic();
        bq_t exp = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        cap.delete();
        tx_ready0 = 1'b1;
        start_two_words();
        n_checks++;
        if (BUSY0 !== 1'b1) begin n_fail++; $display("FAIL tx_busy_set: got %b expected 1", BUSY0); end
        n_checks++;
        if (tx_valid0 !== 1'b1 || tx_data0 !== 8'hA5) begin n_fail++; $display("FAIL tx_first_byte: valid %b data %h expected 1 a5", tx_valid0, tx_data0); end
        wait_cap(7, "tx_basic");
        n_checks++;
        if (BUSY0 !== 1'b0 || tx_valid0 !== 1'b0) begin n_fail++; $display("FAIL tx_busy_clear: busy %b valid %b expected 0 0", BUSY0, tx_valid0); end
        cmp_cap(exp, "tx_basic_bytes");
    endtask

    task automatic test_tx_backpressure();
        bq_t exp = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        bit stalled = 0, stable = 1;
        cap.delete();
        tx_ready0 = 1'b1;
        start_two_words();
        for (int k = 0; k < 60 && !stalled; k++) begin
            if (tx_valid0 && tx_data0 == 8'h34) begin
                tx_ready0 = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    ENA0 = 1'b0;
                    if (!(tx_valid0 === 1'b1 && tx_data0 === 8'h34)) stable = 0;
                    if (i == 3) begin
                        n_checks++;
                        if (BUSY0 !== 1'b1) begin n_fail++; $display("FAIL tx_busy_stall: got %b expected 1", BUSY0); end
                        ENA0 = 1'b1; DATA0 = 16'hFFFF; MSG_LEN_IN0 = 8'd1;
                    end
                end
                ENA0 = 1'b0;
                tx_ready0 = 1'b1;
                stalled = 1;
            end else begin
                tick();
            end
        end
        n_checks++;
        if (!stalled || !stable) begin n_fail++; $display("FAIL tx_hold: stalled %0d stable %0d expected 1 1", stalled, stable); end
        wait_cap(7, "tx_bp");
        repeat (6) tick();
        cmp_cap(exp, "tx_bp_bytes");
    endtask

    task automatic test_tx_random();
        for (int it = 0; it < 4; it++) begin
            int n = $urandom_range(1, 6);
            int idx = 0;
            int k = 0;
            wq_t w;
            bq_t exp;
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            exp = frame_of(8'(n), w, 8'h00);
            cap.delete();
            while ((cap.size() < exp.size() || idx < n) && k < 500) begin
                tx_ready0 = 1'($urandom_range(0, 1));
                if (idx < n && !BUSY0 && $urandom_range(0, 2) != 0) begin
                    ENA0 = 1'b1; DATA0 = w[idx];
                    MSG_LEN_IN0 = (idx == 0) ? 8'(n) : 8'($urandom);
                    idx++;
                end else begin
                    ENA0 = 1'b0;
                end
                tick();
                k++;
            end
            ENA0 = 1'b0;
            tx_ready0 = 1'b1;
            repeat (3) tick();
            cmp_cap(exp, "tx_random");
        end
    endtask

    task automatic test_rx_good();
        int g = c_got0;
        bq_t f = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(0, f, 0);
        repeat (2) tick();
        n_checks++;
        if (c_got0 - g !== 1 || MSG_LEN0 !== 8'd2 || RX_COUNT0 !== 9'd2) begin
            n_fail++; $display("FAIL rx_good: pulses %0d len %0d cnt %0d expected 1 2 2", c_got0 - g, MSG_LEN0, RX_COUNT0);
        end
        n_checks++;
        if (FIFO_Q0 !== 16'h1234) begin n_fail++; $display("FAIL rx_q0: got %h expected 1234", FIFO_Q0); end
        RD_REQ0 = 1'b1; tick(); RD_REQ0 = 1'b0;
        n_checks++;
        if (FIFO_Q0 !== 16'hABCD || RX_COUNT0 !== 9'd1) begin n_fail++; $display("FAIL rx_q1: got %h cnt %0d expected abcd 1", FIFO_Q0, RX_COUNT0); end
        RD_REQ0 = 1'b1; tick(); tick(); RD_REQ0 = 1'b0;
        n_checks++;
        if (RX_COUNT0 !== 9'd0 || FIFO_Q0 !== 16'h0) begin n_fail++; $display("FAIL rx_empty_pop: cnt %0d q %h expected 0 0", RX_COUNT0, FIFO_Q0); end
    endtask

    task automatic test_rx_bad_and_simul();
        int g = c_got0, c = c_crc0;
        bq_t f = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        wq_t w;
        send_frame(0, f, 0);
        repeat (2) tick();
        n_checks++;
        if (c_crc0 - c !== 1 || c_got0 != g || RX_COUNT0 !== 9'd0) begin
            n_fail++; $display("FAIL rx_crc: crc %0d got %0d cnt %0d expected 1 0 0", c_crc0 - c, c_got0 - g, RX_COUNT0);
        end
        w = '{16'($urandom), 16'($urandom)};
        send_frame(0, frame_of(8'd2, w, 8'h00), 1);
        foreach (w[i]) rx_model.push_back(w[i]);
        w = '{16'($urandom), 16'($urandom), 16'($urandom)};
        f = frame_of(8'd3, w, 8'h00);
        for (int i = 0; i < f.size() - 1; i++) send_byte(0, f[i]);
        n_checks++;
        if (FIFO_Q0 !== rx_model[0]) begin n_fail++; $display("FAIL rx_simul_head: got %h expected %h", FIFO_Q0, rx_model[0]); end
        rx_data0 = f[f.size() - 1]; rx_valid0 = 1'b1; RD_REQ0 = 1'b1;
        tick();
        rx_valid0 = 1'b0; RD_REQ0 = 1'b0;
        void'(rx_model.pop_front());
        foreach (w[i]) rx_model.push_back(w[i]);
        tick();
        n_checks++;
        if (RX_COUNT0 !== 9'd4 || MSG_LEN0 !== 8'd3) begin n_fail++; $display("FAIL rx_simul_count: cnt %0d len %0d expected 4 3", RX_COUNT0, MSG_LEN0); end
        drain_check("rx_simul_drain");
    endtask

    task automatic test_rx_random();
        int g = c_got0, c = c_crc0, eg = 0, ec = 0;
        for (int it = 0; it < 8; it++) begin
            int len = $urandom_range(0, 5);
            bit bad = ($urandom_range(0, 2) == 0);
            wq_t w;
            repeat ($urandom_range(0, 2)) send_byte(0, 8'($urandom_range(0, 8'hA4)));
            if (len == 0) begin
                send_frame(0, '{8'hA5, 8'h00}, 2);
            end else begin
                for (int i = 0; i < len; i++) w.push_back(16'($urandom));
                send_frame(0, frame_of(8'(len), w, bad ? 8'($urandom_range(1, 255)) : 8'h00), 3);
                if (bad) ec++;
                else begin eg++; foreach (w[i]) rx_model.push_back(w[i]); end
            end
        end
        repeat (2) tick();
        n_checks++;
        if (c_got0 - g !== eg || c_crc0 - c !== ec) begin
            n_fail++; $display("FAIL rx_random_pulses: got %0d crc %0d expected %0d %0d", c_got0 - g, c_crc0 - c, eg, ec);
        end
        drain_check("rx_random_drain");
    endtask

    task automatic test_rx_timeout();
        int t0 = c_tmo0, k = 0, g;
        wq_t w;
        send_byte(0, 8'hA5); send_byte(0, 8'h02); send_byte(0, 8'h12);
        while (tmo0 !== 1'b1 && k < T0 + 20) begin tick(); k++; end
        n_checks++;
        if (k < T0 - 1 || k > T0 + 1) begin n_fail++; $display("FAIL rx_timeout_delay: got %0d cycles expected %0d", k, T0); end
        tick();
        n_checks++;
        if (c_tmo0 - t0 !== 1 || RX_COUNT0 !== 9'd0) begin n_fail++; $display("FAIL rx_timeout: pulses %0d cnt %0d expected 1 0", c_tmo0 - t0, RX_COUNT0); end
        g = c_got0;
        w = '{16'hBEEF};
        send_frame(0, frame_of(8'd1, w, 8'h00), 0);
        rx_model.push_back(16'hBEEF);
        repeat (2) tick();
        n_checks++;
        if (c_got0 - g !== 1 || RX_COUNT0 !== 9'd1 || FIFO_Q0 !== 16'hBEEF) begin
            n_fail++; $display("FAIL rx_after_timeout: got %0d cnt %0d q %h expected 1 1 beef", c_got0 - g, RX_COUNT0, FIFO_Q0);
        end
    endtask

    task automatic test_overflow();
        int o = c_ovf1, g = c_got1, c = c_crc1;
        wq_t w5 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        wq_t w4 = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
        send_frame(1, frame_of(8'd5, w5, 8'h00), 0);
        repeat (2) tick();
        n_checks++;
        if (c_ovf1 - o !== 1 || c_got1 != g || RX_COUNT1 !== 3'd0) begin
            n_fail++; $display("FAIL ovf_len5: ovf %0d got %0d cnt %0d expected 1 0 0", c_ovf1 - o, c_got1 - g, RX_COUNT1);
        end
        send_frame(1, frame_of(8'd4, w4, 8'h00), 0);
        repeat (2) tick();
        n_checks++;
        if (c_got1 - g !== 1 || RX_COUNT1 !== 3'd4 || FIFO_Q1 !== 16'h0A0A) begin
            n_fail++; $display("FAIL ovf_fill: got %0d cnt %0d q %h expected 1 4 0a0a", c_got1 - g, RX_COUNT1, FIFO_Q1);
        end
        send_frame(1, frame_of(8'd1, '{16'h7777}, 8'h5A), 0);
        repeat (2) tick();
        n_checks++;
        if (c_ovf1 - o !== 2 || c_crc1 != c || RX_COUNT1 !== 3'd4) begin
            n_fail++; $display("FAIL ovf_priority: ovf %0d crc %0d cnt %0d expected 2 0 4", c_ovf1 - o, c_crc1 - c, RX_COUNT1);
        end
    endtask

    task automatic test_reset_midframe();
        int g, c, t, o;
        wq_t w = '{16'h5A5A};
        tx_ready0 = 1'b1;
        MSG_LEN_IN0 = 8'd3; ENA0 = 1'b1;
        DATA0 = 16'h0102; rx_data0 = 8'hA5; rx_valid0 = 1'b1; tick();
        DATA0 = 16'h0304; rx_data0 = 8'h02; tick();
        DATA0 = 16'h0506; rx_data0 = 8'h12; tick();
        ENA0 = 1'b0; rx_valid0 = 1'b0;
        tick();
        g = c_got0; c = c_crc0; t = c_tmo0; o = c_ovf0;
        RST = 1'b1;
        tick();
        n_checks++;
        if ({tx_valid0, tx_data0, rx_ready0, BUSY0, FIFO_Q0, RX_COUNT0, MSG_LEN0, got0, crc0, tmo0, ovf0} !== 48'h0) begin
            n_fail++; $display("FAIL midreset_outputs: valid %b data %h busy %b q %h cnt %0d len %0d expected all 0", tx_valid0, tx_data0, BUSY0, FIFO_Q0, RX_COUNT0, MSG_LEN0);
        end
        RST = 1'b0;
        rx_model.delete();
        repeat (2) tick();
        cap.delete();
        MSG_LEN_IN0 = 8'd1; DATA0 = 16'h5A5A; ENA0 = 1'b1; tick(); ENA0 = 1'b0;
        send_frame(0, frame_of(8'd1, w, 8'h00), 0);
        wait_cap(5, "midreset_tx");
        cmp_cap(frame_of(8'd1, w, 8'h00), "midreset_tx_bytes");
        n_checks++;
        if (c_got0 - g !== 1 || c_crc0 != c || c_tmo0 != t || c_ovf0 != o || RX_COUNT0 !== 9'd1 || FIFO_Q0 !== 16'h5A5A) begin
            n_fail++; $display("FAIL midreset_rx: got %0d err %0d/%0d/%0d cnt %0d q %h expected 1 0/0/0 1 5a5a", c_got0 - g, c_crc0 - c, c_tmo0 - t, c_ovf0 - o, RX_COUNT0, FIFO_Q0);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_backpressure();
        test_tx_random();
        test_rx_good();
        test_rx_bad_and_simul();
        test_rx_random();
        test_rx_timeout();
        test_overflow();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
